// File: rtl/fp32_pkg.sv
// fp32_pkg: shared IEEE-754 single-precision constants, FSM states and operand classes
package fp32_pkg;
  localparam int EXP_W = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS = 127;
  localparam logic [31:0] QNAN = 32'hFFFF_FFFF;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, ROUND, DONE} state_t;
  typedef enum logic [2:0] {ZERO, SUBN, NORM, INF, NAN} fp_class_t;
endpackage

// File: rtl/fp32_unpack.sv
// fp32_unpack: classify an fp32 operand and normalize it to a [1,2) mantissa with signed biased exponent
module fp32_unpack
  import fp32_pkg::*;
(
  input  logic [31:0]       x,
  output logic              sign,
  output fp_class_t         cls,
  output logic [23:0]       mant,
  output logic signed [9:0] expo
);
  logic [EXP_W-1:0] e;
  logic [FRAC_W-1:0] f;
  logic [4:0] lz;
  assign sign = x[31];
  assign e = x[30:23];
  assign f = x[22:0];
  always_comb begin
    lz = '0;
    for (int i = 0; i < FRAC_W; i++) if (f[i]) lz = 5'(22 - i);
    cls = (e == '1) ? ((f == '0) ? INF : NAN) : (e == '0) ? ((f == '0) ? ZERO : SUBN) : NORM;
    mant = (e == '0) ? ({f, 1'b0} << lz) : {1'b1, f};
    expo = (e == '0) ? -$signed({5'd0, lz}) : $signed({2'd0, e});
  end
endmodule

// File: rtl/floating_div.sv
// floating_div: fixed-latency fp32 divider, restoring division with round-to-nearest-even
module floating_div
  import fp32_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LATENCY = 30
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_res
);
  localparam int STEPS = LATENCY - 3;
  state_t state, nxt;
  logic [31:0] a_r, b_r, spec_val, spec_r, res, pk, rnd;
  logic sa, sb, sign, nan_c, special, spec, ge, norm, st, up;
  fp_class_t ca, cb;
  logic [23:0] ma, mb, dvs;
  logic signed [9:0] ea, eb, e, e_n;
  logic [24:0] rem, rem_n;
  logic [26:0] q;
  logic [4:0] cnt, sh;
  logic [25:0] m26, m_sh, lost;
  logic [8:0] ef;
  fp32_unpack u_a (.x(a_r), .sign(sa), .cls(ca), .mant(ma), .expo(ea));
  fp32_unpack u_b (.x(b_r), .sign(sb), .cls(cb), .mant(mb), .expo(eb));
  assign o_busy = state != IDLE;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = i_start ? UNPACK : IDLE;
      UNPACK:  nxt = DIVIDE;
      DIVIDE:  nxt = (cnt == 5'(STEPS - 1)) ? ROUND : DIVIDE;
      ROUND:   nxt = DONE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    nan_c = ca == NAN || cb == NAN || (ca == ZERO && cb == ZERO) || (ca == INF && cb == INF);
    special = nan_c || ca == INF || cb == INF || ca == ZERO || cb == ZERO;
    spec_val = nan_c ? QNAN : (ca == INF || cb == ZERO) ? {sa ^ sb, POS_INF[30:0]} : {sa ^ sb, 31'd0};
    ge = rem >= {1'b0, dvs};
    rem_n = ge ? rem - {1'b0, dvs} : rem;
  end
  // Normalize, denormalize on underflow, then RNE; the hidden bit carries into the exponent field
  always_comb begin
    norm = q[26];
    e_n = norm ? e : e - 10'sd1;
    m26 = norm ? q[26:1] : q[25:0];
    sh = (e_n > 10'sd0) ? 5'd0 : (e_n < -10'sd24) ? 5'd26 : 5'(10'sd1 - e_n);
    m_sh = m26 >> sh;
    lost = m26 & ~({26{1'b1}} << sh);
    st = (norm & q[0]) | (rem != '0) | (|lost);
    up = m_sh[1] & (m_sh[0] | st | m_sh[2]);
    ef = (e_n > 10'sd0) ? e_n[8:0] - 9'd1 : 9'd0;
    pk = {ef, 23'd0} + {8'd0, m_sh[25:2]} + {31'd0, up};
    rnd = (pk[31:23] >= 9'd255) ? {sign, POS_INF[30:0]} : {sign, pk[30:0]};
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      a_r <= '0;
      b_r <= '0;
      rem <= '0;
      dvs <= '0;
      q <= '0;
      cnt <= '0;
      e <= '0;
      sign <= 1'b0;
      spec <= 1'b0;
      spec_r <= '0;
      res <= '0;
      o_done <= 1'b0;
      o_res <= '0;
    end else begin
      o_done <= state == DONE;
      if (state == IDLE && i_start) begin
        a_r <= i_a;
        b_r <= i_b;
      end
      if (state == UNPACK) begin
        rem <= {1'b0, ma};
        dvs <= mb;
        q <= '0;
        cnt <= '0;
        e <= ea - eb + $signed(10'(BIAS));
        sign <= sa ^ sb;
        spec <= special;
        spec_r <= spec_val;
      end
      if (state == DIVIDE) begin
        q <= {q[25:0], ge};
        rem <= {rem_n[23:0], 1'b0};
        cnt <= cnt + 5'd1;
      end
      if (state == ROUND) res <= spec ? spec_r : rnd;
      if (state == DONE) o_res <= res;
    end
endmodule

// File: doc/floating_div.md
Name: floating_div

Overview:
Sequential IEEE-754 single-precision divider, the inverse companion of the team's floating-point multiplier. It computes o_res = i_a / i_b with a start/done handshake and a fixed latency. It uses the same special-value conventions as the multiplier, so both can sit behind one arithmetic-unit wrapper. It shares the unpack logic and constants package with the multiplier.

Parameters:
WIDTH, 32, operand/result width; only 32 is supported.
LATENCY, 30, cycles from accepted i_start to o_done; fixed, not tunable.

Ports:
i_clk  input  1  clock; all state updates on rising edge.
i_rst  input  1  asynchronous, active-high reset.
i_start  input  1  request; accepted only when o_busy=0.
i_a  input  32  dividend; sampled on the accept cycle.
i_b  input  32  divisor; sampled on the accept cycle.
o_busy  output  1  high from the cycle after accept until o_done.
o_done  output  1  one-cycle pulse; o_res is valid in that cycle.
o_res  output  32  quotient; held until the next o_done.

Behaviour:
- Reset (async, any state): state=IDLE, o_busy=0, o_done=0, o_res=0.
- Accept: IDLE and i_start=1 at edge N. Operands are registered, and o_busy=1 from N+1.
  - o_done=1 and o_res are updated at edge N+30. o_busy drops in the same cycle.
  - i_start while busy is ignored. Back-to-back operation is allowed: start may be accepted in the o_done cycle.
- States:
  - IDLE -> UNPACK: 1 cycle. Classify operands; for subnormals, normalize via leading-zero count to 24-bit mantissa in [1,2) and a signed 10-bit exponent.
  - UNPACK -> DIVIDE: 27 cycles of restoring division, one quotient bit per cycle, MSB weight 2^0.
  - DIVIDE -> ROUND: 1 cycle.
  - ROUND -> DONE: 1 cycle, pulse o_done, then return to IDLE.
- Special cases: decided in UNPACK, but the fixed latency is still honoured.
  - sign = a.sign XOR b.sign.
  - NaN operand, 0/0, or Inf/Inf -> 32'hFFFF_FFFF (canonical NaN, same as the multiplier).
  - x/0 (x nonzero, not NaN) -> signed Inf.
  - Inf/finite -> signed Inf.
  - finite/Inf -> signed zero.
  - 0/finite nonzero -> signed zero.
- Exponent: e = ea - eb + 127, signed 10-bit. If quotient bit q[26]=0, shift the quotient left by 1 and decrement e.
- Round fields: 24-bit significand + guard + round; sticky = OR(dropped bits, remainder != 0).
- Underflow: if e <= 0, right-shift the significand by 1-e (saturate at 26) with dropped bits ORed into sticky, and set the exponent field to 0.
- Rounding is round-to-nearest-even.
  - A carry out of a subnormal produces the min normal.
  - A carry out of 1.11..1 increments the exponent.
- Overflow: e >= 255 after rounding -> signed Inf. No saturation to max finite.
- The remainder compare is 25-bit; no other arithmetic exceeds 10 bits for exponents.

Decomposition:
- Shared package fp32_pkg:
  - field widths and bias 127.
  - constants QNAN=32'hFFFFFFFF, POS_INF=32'h7F800000.
  - the state enum IDLE/UNPACK/DIVIDE/ROUND/DONE.
  - class codes ZERO/SUBN/NORM/INF/NAN.
- One combinational sub-module, fp32_unpack: classify, hidden bit, LZC normalize. It is reused by the multiplier. The divider iteration and rounding stay inline.

Test Plan:
- 6.0/2.0: 40C00000 / 40000000 -> 40400000, with o_done exactly 30 cycles after accept. 1.0/3.0: 3F800000 / 40400000 -> 3EAAAAAB.
- Specials:
  - 3F800000/00000000 -> 7F800000
  - BF800000/80000000 -> 7F800000
  - 00000000/00000000 -> FFFFFFFF
  - 7F800000/FF800000 -> FFFFFFFF
  - 80000000/40000000 -> 80000000
- Subnormal in/out and RNE:
  - 00400000/00800000 -> 3F000000
  - 00000003/40000000 -> 00000002 (tie to even)
  - 00000001/40000000 -> 00000000
- Overflow: 7F7FFFFF / 3F000000 -> 7F800000. Underflow to subnormal: 00800000 / 40000000 -> 00400000.
- Handshake:
  - i_start held high while busy with different operands -> only the first result appears, then a new accept in the o_done cycle.
  - i_rst pulsed mid-DIVIDE -> outputs immediately 0, no o_done; next op completes correctly.
- Random: 10k random operand pairs vs. a reference model (NaN compared as class) -> bit-exact results.
